// File: rtl/chip_blitter.sv
// rtl/chip_blitter.sv - sprite blitter that streams a ROM-held chip image to a VGA pixel port
module chip_blitter #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int COLOUR_W = 8,
    parameter int ROM_LAT  = 1,
    parameter int KEY      = 0,
    parameter int ADDR_W   = 9
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [7:0]          xin,
    input  logic [6:0]          yin,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          xout,
    output logic [6:0]          yout,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int NPIX = SPRITE_W * SPRITE_H;
    localparam int KW   = $clog2(NPIX);
    localparam int XB   = $clog2(SPRITE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k;
    logic [1:0]          drain_cnt;
    logic [7:0]          x_l;
    logic [6:0]          y_l;
    logic [1:0]          mode_l;
    logic [COLOUR_W-1:0] bg_l;

    logic                fetch;
    logic                erase_l;
    logic                bank;
    logic [7:0]          x_px;
    logic [6:0]          y_px;

    logic [ROM_LAT-1:0]  pv;
    logic [ROM_LAT-1:0]  pe;
    logic [7:0]          px [ROM_LAT];
    logic [6:0]          py [ROM_LAT];

    assign fetch   = (state == S_FETCH);
    assign erase_l = mode_l[1];
    // Erase always reads the red (bank 0) image as its footprint mask.
    assign bank    = ~mode_l[1] & mode_l[0];
    assign x_px    = x_l + 8'(k[XB-1:0]);
    assign y_px    = y_l + 7'(k[KW-1:XB]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            k         <= '0;
            drain_cnt <= '0;
            x_l       <= '0;
            y_l       <= '0;
            mode_l    <= '0;
            bg_l      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_l    <= xin;
                        y_l    <= yin;
                        mode_l <= mode;
                        bg_l   <= bg_colour;
                        k      <= '0;
                    end
                end
                S_FETCH: begin
                    k         <= k + KW'(1);
                    drain_cnt <= '0;
                end
                S_DRAIN: drain_cnt <= drain_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (k == KW'(NPIX - 1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'(ROM_LAT - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rom_addr = '0;
        if (fetch) begin
            rom_addr = ADDR_W'(k) + (bank ? ADDR_W'(NPIX) : ADDR_W'(0));
        end
    end

    // Sideband travels alongside the ROM read so it lines up with rom_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            pv[0] <= fetch;
            pe[0] <= erase_l;
            px[0] <= x_px;
            py[0] <= y_px;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign xout   = px[ROM_LAT-1];
    assign yout   = py[ROM_LAT-1];
    assign plot   = pv[ROM_LAT-1] && (rom_q != COLOUR_W'(KEY));
    assign colour = pv[ROM_LAT-1] ? (pe[ROM_LAT-1] ? bg_l : rom_q) : '0;
    assign busy   = (state == S_FETCH) || (state == S_DRAIN);
    assign done   = (state == S_DONE);

endmodule
